// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, IIR interrupt ids, IER layout and
// the serial frame-length helper.
package uart_pkg;

    // CPU-visible register offsets (DLAB=0 view)
    typedef enum logic [2:0] {
        CSR_RBR_THR = 3'b000,
        CSR_IER     = 3'b001,
        CSR_IIR_FCR = 3'b010,
        CSR_LCR     = 3'b011,
        CSR_MCR     = 3'b100,
        CSR_LSR     = 3'b101,
        CSR_MSR     = 3'b110,
        CSR_SCR     = 3'b111
    } csr_t;

    // Interrupt identification codes reported in IIR[3:1]
    typedef enum logic [2:0] {
        IIR_MSR  = 3'b000,
        IIR_THRE = 3'b001,
        IIR_RDA  = 3'b010,
        IIR_RLS  = 3'b011,
        IIR_CTI  = 3'b110
    } iir_id_t;

    // Interrupt enable register, MSB first
    typedef struct packed {
        logic edssi;
        logic elsi;
        logic etbei;
        logic erbfi;
    } ier_t;

    // Total bits per character: start + data + parity + stop(s), 7..12
    function automatic logic [3:0] frame_bits(input logic [1:0] wls,
                                              input logic       stb,
                                              input logic       pen);
        return 4'd6 + {2'b00, wls} + {3'b000, pen} + (stb ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout counter: counts baud ticks of RX inactivity while the
// RX FIFO holds data and flags the tick on which the timeout is reached.
module uart_rx_timeout #(
    parameter int unsigned TIMEOUT_CHARS = 4,
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_push_i,
    input  logic       rx_pop_i,
    input  logic [4:0] rx_count_i,
    input  logic       baud_tick,
    input  logic [3:0] frame_bits_i,
    output logic       timeout_o
);
    import uart_pkg::*;

    localparam int unsigned CHAR_TICKS = TIMEOUT_CHARS * TICKS_PER_BIT;
    localparam int unsigned MAX_LIMIT  = CHAR_TICKS * 12;
    localparam int unsigned CW         = $clog2(MAX_LIMIT + 1);

    logic [CW-1:0] count_q, count_d;
    logic          reload;
    logic [31:0]   limit_m1;

    // Next count and timeout detection; limit follows the live frame format,
    // and >= keeps a mid-count format shrink from skipping past the limit
    always_comb begin
        reload    = rx_push_i || rx_pop_i || (rx_count_i == 5'd0);
        limit_m1  = CHAR_TICKS * 32'(frame_bits_i) - 32'd1;
        count_d   = count_q;
        if (reload) begin
            count_d = '0;
        end else if (baud_tick && (count_q != '1)) begin
            count_d = count_q + CW'(1);
        end
        timeout_o = baud_tick && !reload && (32'(count_q) >= limit_m1);
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_intr_ctrl.sv
// UART interrupt controller: IER register, pending-interrupt flags, priority
// encoding into IIR and the interrupt request output.
module uart_intr_ctrl #(
    parameter int unsigned TIMEOUT_CHARS = 4,
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic       rd_i,
    input  logic [2:0] addr_i,
    input  logic [7:0] din_i,
    input  logic       dlab_i,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       fifo_ena_i,
    input  logic [4:0] rx_count_i,
    input  logic [3:0] rx_threshold_i,
    input  logic       rx_push_i,
    input  logic       rx_pop_i,
    input  logic       tx_empty_i,
    input  logic       lsr_err_i,
    input  logic       msr_delta_i,
    input  logic       baud_tick,
    output logic [3:0] ier_o,
    output logic [7:0] iir_o,
    output logic       irq_o
);
    import uart_pkg::*;

    ier_t    ier_q, ier_d;
    logic    rls_q, rls_d;
    logic    thre_q, thre_d;
    logic    msr_q, msr_d;
    logic    cti_q, cti_d;
    logic    tx_empty_q;

    logic    ier_wr, thr_wr, lsr_rd, iir_rd, msr_rd;
    logic    rda, any;
    logic    timeout_hit;
    logic    thre_set, thre_clr;
    logic [4:0] thr_eff;
    iir_id_t id;
    logic    unused_din;

    assign unused_din = ^din_i[7:4];

    uart_rx_timeout #(
        .TIMEOUT_CHARS(TIMEOUT_CHARS),
        .TICKS_PER_BIT(TICKS_PER_BIT)
    ) u_timeout (
        .clk          (clk),
        .rst          (rst),
        .rx_push_i    (rx_push_i),
        .rx_pop_i     (rx_pop_i),
        .rx_count_i   (rx_count_i),
        .baud_tick    (baud_tick),
        .frame_bits_i (frame_bits(wls_i, stb_i, pen_i)),
        .timeout_o    (timeout_hit)
    );

    // Access decode and prioritised interrupt identification
    always_comb begin
        ier_wr  = wr_i && !dlab_i && (csr_t'(addr_i) == CSR_IER);
        thr_wr  = wr_i && !dlab_i && (csr_t'(addr_i) == CSR_RBR_THR);
        lsr_rd  = rd_i && (csr_t'(addr_i) == CSR_LSR);
        iir_rd  = rd_i && (csr_t'(addr_i) == CSR_IIR_FCR);
        msr_rd  = rd_i && (csr_t'(addr_i) == CSR_MSR);

        thr_eff = (rx_threshold_i == 4'd0) ? 5'd1 : {1'b0, rx_threshold_i};
        rda     = ier_q.erbfi && (rx_count_i >= thr_eff);

        any = 1'b1;
        if (rls_q && ier_q.elsi) begin
            id = IIR_RLS;
        end else if (rda) begin
            id = IIR_RDA;
        end else if (cti_q && ier_q.erbfi) begin
            id = IIR_CTI;
        end else if (thre_q && ier_q.etbei) begin
            id = IIR_THRE;
        end else if (msr_q && ier_q.edssi) begin
            id = IIR_MSR;
        end else begin
            id  = IIR_MSR;
            any = 1'b0;
        end
    end

    assign iir_o = {(fifo_ena_i ? 2'b11 : 2'b00), 2'b00, id, ~any};
    assign irq_o = ~iir_o[0];
    assign ier_o = ier_q;

    // Pending-flag and IER next state; a set beats a simultaneous clear
    always_comb begin
        ier_d    = ier_wr ? ier_t'(din_i[3:0]) : ier_q;
        rls_d    = lsr_err_i   ? 1'b1 : (lsr_rd ? 1'b0 : rls_q);
        msr_d    = msr_delta_i ? 1'b1 : (msr_rd ? 1'b0 : msr_q);
        thre_set = (tx_empty_i && !tx_empty_q) || (ier_wr && din_i[1] && tx_empty_i);
        thre_clr = thr_wr || (iir_rd && (iir_o[3:1] == IIR_THRE));
        thre_d   = thre_set ? 1'b1 : (thre_clr ? 1'b0 : thre_q);
        cti_d    = timeout_hit ? 1'b1
                 : ((rx_pop_i || (rx_count_i == 5'd0)) ? 1'b0 : cti_q);
    end

    // State registers; reset overrides every simultaneous set or write
    always_ff @(posedge clk) begin
        if (rst) begin
            ier_q      <= '0;
            rls_q      <= 1'b0;
            thre_q     <= 1'b0;
            msr_q      <= 1'b0;
            cti_q      <= 1'b0;
            tx_empty_q <= 1'b1;
        end else begin
            ier_q      <= ier_d;
            rls_q      <= rls_d;
            thre_q     <= thre_d;
            msr_q      <= msr_d;
            cti_q      <= cti_d;
            tx_empty_q <= tx_empty_i;
        end
    end

endmodule

// File: tb/tb_uart_intr_ctrl.sv
// Self-checking bench for uart_intr_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_uart_intr_ctrl;

    localparam int TC  = 4;
    localparam int TPB = 16;

    logic       clk = 1'b0;
    logic       rst, wr_i, rd_i, dlab_i, stb_i, pen_i, fifo_ena_i;
    logic [2:0] addr_i;
    logic [7:0] din_i;
    logic [1:0] wls_i;
    logic [4:0] rx_count_i;
    logic [3:0] rx_threshold_i;
    logic       rx_push_i, rx_pop_i, tx_empty_i, lsr_err_i, msr_delta_i, baud_tick;
    logic [3:0] ier_o;
    logic [7:0] iir_o;
    logic       irq_o;

    always #5 clk = ~clk;

    uart_intr_ctrl #(.TIMEOUT_CHARS(TC), .TICKS_PER_BIT(TPB)) dut (
        .clk(clk), .rst(rst), .wr_i(wr_i), .rd_i(rd_i), .addr_i(addr_i),
        .din_i(din_i), .dlab_i(dlab_i), .wls_i(wls_i), .stb_i(stb_i),
        .pen_i(pen_i), .fifo_ena_i(fifo_ena_i), .rx_count_i(rx_count_i),
        .rx_threshold_i(rx_threshold_i), .rx_push_i(rx_push_i),
        .rx_pop_i(rx_pop_i), .tx_empty_i(tx_empty_i), .lsr_err_i(lsr_err_i),
        .msr_delta_i(msr_delta_i), .baud_tick(baud_tick),
        .ier_o(ier_o), .iir_o(iir_o), .irq_o(irq_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Behavioural model state
    bit [3:0] m_ier;
    bit       m_rls, m_thre, m_msr, m_cti, m_txe_prev;
    int       m_idle_ticks;

    typedef struct packed {
        logic [7:0] iir;
        logic [7:0] mask;
        logic       ier_chk;
        logic [3:0] ier;
    } lit_t;
    lit_t  lit_q[$];
    string lit_name_q[$];

    // Interrupt id reported by the model: first active source in priority order
    function automatic logic [7:0] model_iir();
        int       thr = (rx_threshold_i == 0) ? 1 : int'(rx_threshold_i);
        bit       act [5];
        bit [2:0] ids [5];
        bit [2:0] id  = 3'b000;
        bit       any = 0;
        act[0] = m_rls  && m_ier[2];                      ids[0] = 3'b011;
        act[1] = m_ier[0] && (int'(rx_count_i) >= thr);  ids[1] = 3'b010;
        act[2] = m_cti  && m_ier[0];                      ids[2] = 3'b110;
        act[3] = m_thre && m_ier[1];                      ids[3] = 3'b001;
        act[4] = m_msr  && m_ier[3];                      ids[4] = 3'b000;
        for (int k = 4; k >= 0; k--) begin
            if (act[k]) begin
                id  = ids[k];
                any = 1;
            end
        end
        return {(fifo_ena_i ? 2'b11 : 2'b00), 2'b00, id, ~any};
    endfunction

    // Advance the model by one clock using the inputs applied this cycle
    task automatic model_step();
        bit [7:0] cur   = model_iir();
        int       bits  = 1 + (5 + int'(wls_i)) + int'(pen_i) + (stb_i ? 2 : 1);
        int       limit = TC * TPB * bits;
        bit       activity = rx_push_i || rx_pop_i || (rx_count_i == 0);
        bit       ier_w = wr_i && !dlab_i && addr_i == 3'd1;
        bit       thr_w = wr_i && !dlab_i && addr_i == 3'd0;
        bit       timeout = baud_tick && !activity && (m_idle_ticks + 1 >= limit);
        bit       t_set, t_clr;
        if (rst) begin
            m_ier = 0; m_rls = 0; m_thre = 0; m_msr = 0; m_cti = 0;
            m_txe_prev = 1; m_idle_ticks = 0;
            return;
        end
        t_set = (tx_empty_i && !m_txe_prev) || (ier_w && din_i[1] && tx_empty_i);
        t_clr = thr_w || (rd_i && addr_i == 3'd2 && cur[3:1] == 3'b001);
        if (t_set) m_thre = 1; else if (t_clr) m_thre = 0;
        if (lsr_err_i) m_rls = 1; else if (rd_i && addr_i == 3'd5) m_rls = 0;
        if (msr_delta_i) m_msr = 1; else if (rd_i && addr_i == 3'd6) m_msr = 0;
        if (timeout) m_cti = 1; else if (rx_pop_i || rx_count_i == 0) m_cti = 0;
        if (activity) m_idle_ticks = 0; else if (baud_tick) m_idle_ticks++;
        if (ier_w) m_ier = din_i[3:0];
        m_txe_prev = tx_empty_i;
    endtask

    // Compare DUT outputs with the model every cycle, plus any literal expectation
    always @(negedge clk) begin
        if (chk_en) begin
            automatic logic [7:0] e = model_iir();
            n_tests++;
            if (iir_o !== e) begin
                n_fail++;
                $display("FAIL model_iir t=%0t got %02h want %02h", $time, iir_o, e);
            end
            n_tests++;
            if (irq_o !== ~e[0]) begin
                n_fail++;
                $display("FAIL model_irq t=%0t got %b want %b", $time, irq_o, ~e[0]);
            end
            n_tests++;
            if (ier_o !== m_ier) begin
                n_fail++;
                $display("FAIL model_ier t=%0t got %h want %h", $time, ier_o, m_ier);
            end
            if (lit_q.size() > 0) begin
                automatic lit_t  l  = lit_q.pop_front();
                automatic string nm = lit_name_q.pop_front();
                n_tests++;
                if ((iir_o & l.mask) !== (l.iir & l.mask)) begin
                    n_fail++;
                    $display("FAIL %s iir got %02h want %02h (mask %02h)", nm, iir_o, l.iir, l.mask);
                end
                if (l.mask[0]) begin
                    n_tests++;
                    if (irq_o !== ~l.iir[0]) begin
                        n_fail++;
                        $display("FAIL %s irq got %b want %b", nm, irq_o, ~l.iir[0]);
                    end
                end
                if (l.ier_chk) begin
                    n_tests++;
                    if (ier_o !== l.ier) begin
                        n_fail++;
                        $display("FAIL %s ier got %h want %h", nm, ier_o, l.ier);
                    end
                end
            end
        end
    end

    task automatic expect_lit(input string nm, input logic [7:0] iir,
                              input logic [7:0] mask, input logic ier_chk,
                              input logic [3:0] ier);
        lit_t l;
        l.iir = iir; l.mask = mask; l.ier_chk = ier_chk; l.ier = ier;
        lit_q.push_back(l);
        lit_name_q.push_back(nm);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wr_i = 0; rd_i = 0; rx_push_i = 0; rx_pop_i = 0;
        lsr_err_i = 0; msr_delta_i = 0; baud_tick = 0; rst = 0;
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        wr_i = 1; addr_i = a; din_i = d; dlab_i = 0;
    endtask

    task automatic cpu_rd(input logic [2:0] a);
        rd_i = 1; addr_i = a;
    endtask

    initial begin
        idle();
        addr_i = 0; din_i = 0; dlab_i = 0; wls_i = 2'b11; stb_i = 0; pen_i = 0;
        fifo_ena_i = 0; rx_count_i = 0; rx_threshold_i = 0; tx_empty_i = 1;
        rst = 1;
        cyc();
        chk_en = 1;
        expect_lit("reset", 8'h01, 8'hFF, 1, 4'h0);
        cyc();
        idle();

        // THRE interrupt via IER write while TX is empty, cleared by THR write
        cpu_wr(3'd1, 8'h02); expect_lit("ier_thre", 8'h02, 8'hFF, 1, 4'h2); cyc(); idle();
        cpu_wr(3'd0, 8'h55); expect_lit("thr_clear", 8'h01, 8'hFF, 1, 4'h2); cyc(); idle();

        // RDA at threshold 4 with FIFOs enabled
        fifo_ena_i = 1; rx_threshold_i = 4;
        cpu_wr(3'd1, 8'h01); expect_lit("ier_rx", 8'hC1, 8'hFF, 1, 4'h1); cyc(); idle();
        for (int k = 1; k <= 4; k++) begin
            rx_push_i = 1; rx_count_i = 5'(k);
            if (k == 3) expect_lit("rda_below", 8'hC1, 8'hFF, 0, 4'h0);
            if (k == 4) expect_lit("rda_at", 8'hC4, 8'hFF, 0, 4'h0);
            cyc(); idle();
        end
        rx_pop_i = 1; rx_count_i = 3; expect_lit("rda_pop", 8'hC1, 8'hFF, 0, 4'h0); cyc(); idle();

        // Character timeout, 8N1: 640 ticks with one byte held
        for (int k = 2; k >= 1; k--) begin
            rx_pop_i = 1; rx_count_i = 5'(k); cyc(); idle();
        end
        for (int j = 1; j <= 640; j++) begin
            baud_tick = 1;
            if (j == 639) expect_lit("cti_639", 8'hC1, 8'hFF, 0, 4'h0);
            if (j == 640) expect_lit("cti_640", 8'hCC, 8'hFF, 0, 4'h0);
            cyc();
        end
        idle();
        rx_pop_i = 1; rx_count_i = 0; expect_lit("cti_pop", 8'hC1, 8'hFF, 0, 4'h0); cyc(); idle();

        // RLS pre-empts RDA and THRE; LSR read falls back to RDA
        cpu_wr(3'd1, 8'h07); cyc(); idle();
        for (int k = 1; k <= 4; k++) begin
            rx_push_i = 1; rx_count_i = 5'(k);
            if (k == 4) expect_lit("rda_over_thre", 8'hC4, 8'hFF, 0, 4'h0);
            cyc(); idle();
        end
        lsr_err_i = 1; expect_lit("rls_top", 8'h06, 8'h0F, 0, 4'h0); cyc(); idle();
        cpu_rd(3'd5); expect_lit("lsr_read", 8'h04, 8'h0F, 0, 4'h0); cyc(); idle();

        // MSR set and read together: set wins
        cpu_wr(3'd1, 8'h08); cyc(); idle();
        msr_delta_i = 1; cpu_rd(3'd6); expect_lit("msr_set_wins", 8'h00, 8'h0F, 0, 4'h0); cyc(); idle();
        cpu_rd(3'd6); expect_lit("msr_read", 8'h01, 8'h0F, 0, 4'h0); cyc(); idle();

        // Reset while CTI and RLS are pending
        rx_threshold_i = 8;
        cpu_wr(3'd1, 8'h05); cyc(); idle();
        for (int j = 1; j <= 700; j++) begin
            baud_tick = 1;
            if (j == 700) expect_lit("cti_pre_rst", 8'hCC, 8'hFF, 0, 4'h0);
            cyc();
        end
        idle();
        lsr_err_i = 1; expect_lit("rls_pre_rst", 8'h06, 8'h0F, 0, 4'h0); cyc(); idle();
        rst = 1; fifo_ena_i = 0; lsr_err_i = 1;
        expect_lit("rst_override", 8'h01, 8'hFF, 1, 4'h0); cyc(); idle();

        // Randomized traffic, alternating busy and quiet stretches
        for (int i = 0; i < 24000; i++) begin
            automatic bit quiet = ((i / 1500) % 2) == 1;
            idle();
            if (!quiet && $urandom_range(0, 149) == 0 && rx_count_i < 16) begin
                rx_push_i = 1; rx_count_i = rx_count_i + 5'd1;
            end else if (!quiet && $urandom_range(0, 149) == 0 && rx_count_i > 0) begin
                rx_pop_i = 1; rx_count_i = rx_count_i - 5'd1;
            end
            baud_tick = quiet ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                wr_i = 1; addr_i = 3'($urandom_range(0, 7)); din_i = 8'($urandom);
                dlab_i = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 7) == 0) begin
                rd_i = 1; if (!wr_i) addr_i = 3'($urandom_range(0, 7));
            end
            lsr_err_i   = ($urandom_range(0, 63) == 0);
            msr_delta_i = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) tx_empty_i = ~tx_empty_i;
            if ($urandom_range(0, 499) == 0) fifo_ena_i = ~fifo_ena_i;
            if ($urandom_range(0, 299) == 0) rx_threshold_i = 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                wls_i = 2'($urandom); stb_i = 1'($urandom); pen_i = 1'($urandom);
            end
            rst = ($urandom_range(0, 2999) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_intr_ctrl.md
UART_INTR_CTRL -- requirements
Module: uart_intr_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CHARS, default 4, character times of RX inactivity before a timeout.
REQ-002 SHALL have parameter TICKS_PER_BIT, default 16, baud_tick pulses per serial bit.
REQ-003 SHALL have port clk  in  1  single clock, all logic on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports wr_i/rd_i  in  1 each  CPU write/read strobes, one cycle per access.
REQ-006 SHALL have ports addr_i  in  3  register address, and din_i  in  8  write data.
REQ-007 SHALL have port dlab_i  in  1  LCR divisor-latch access bit.
REQ-008 SHALL have ports wls_i  in  2, stb_i  in  1, pen_i  in  1  LCR frame format.
REQ-009 SHALL have port fifo_ena_i  in  1  FCR FIFO enable.
REQ-010 SHALL have port rx_count_i  in  5  RX FIFO occupancy, 0..16.
REQ-011 SHALL have port rx_threshold_i  in  4  RX trigger level; 0 is treated as 1.
REQ-012 SHALL have ports rx_push_i/rx_pop_i  in  1 each  RX FIFO write/read pulses.
REQ-013 SHALL have port tx_empty_i  in  1  TX FIFO and shifter empty.
REQ-014 SHALL have port lsr_err_i  in  1  OR of the OE/PE/FE/BI update pulses.
REQ-015 SHALL have port msr_delta_i  in  1  modem-status change pulse.
REQ-016 SHALL have port baud_tick  in  1  one-cycle 16x baud pulse.
REQ-017 SHALL have port ier_o  out  4  IER value {EDSSI, ELSI, ETBEI, ERBFI}.
REQ-018 SHALL have port iir_o  out  8  interrupt identification value.
REQ-019 SHALL have port irq_o  out  1  interrupt request, active-high.

Function
REQ-020 SHALL load ier[3:0] <= din_i[3:0] on wr_i with addr_i=001 and dlab_i=0.
REQ-021 SHALL set the pending flags rls_p, thre_p, msr_p and cti_p at the clock edge after their cause; the RDA condition is a live level.
REQ-022 SHALL set rls_p on lsr_err_i and clear it on an LSR read (rd_i, addr 101); on the same cycle, set wins.
REQ-023 SHALL treat RDA as active when rx_count_i >= max(rx_threshold_i, 1).
REQ-024 SHALL compute frame bits as 1 + (5+wls_i) + pen_i + (stb_i ? 2 : 1), giving a range of 7..12.
REQ-025 SHALL reload the timeout counter to 0 on rx_push_i, rx_pop_i, rx_count_i==0, or rst; otherwise it increments on baud_tick, saturating.
REQ-026 SHALL set cti_p when the counter reaches TIMEOUT_CHARS*TICKS_PER_BIT*bits - 1 on a baud_tick with rx_count_i>0, and clear it on rx_pop_i or rx_count_i==0.
REQ-027 SHALL keep tx_empty_q, the registered tx_empty_i.
REQ-028 SHALL set thre_p on a 0->1 edge of tx_empty_i, or on an IER write that sets ETBEI while tx_empty_i=1.
REQ-029 SHALL clear thre_p on a THR write (wr_i, addr 000, dlab_i=0), or on an IIR read (rd_i, addr 010) while iir_o[3:1]=001.
REQ-030 SHALL set msr_p on msr_delta_i and clear it on an MSR read (addr 110); on the same cycle, set wins.
REQ-031 SHALL gate sources by IER and prioritize: RLS(id 011) > RDA(id 010) > CTI(id 110) > THRE(id 001) > MSR(id 000); RDA and CTI are gated by ERBFI.
REQ-032 SHALL drive iir_o combinationally from registers as {fifo_ena_i?2'b11:2'b00, 2'b00, id, ~any}, with id=000 when nothing is pending.
REQ-033 SHALL drive irq_o = ~iir_o[0].
REQ-034 SHALL take a frame-format change mid-count into effect on the next comparison, without reloading the counter.

Reset
REQ-035 SHALL on rst set ier=0, all pending flags=0, counter=0, tx_empty_q=1; outputs are iir_o=8'h01 and irq_o=0.
REQ-036 SHALL let rst override every simultaneous set or write.

Structure
REQ-037 SHALL place the IIR id constants (typedef enum logic [2:0] iir_id_t) and the ier_t packed struct in shared package uart_pkg, next to csr_t.
REQ-038 SHALL place the character-timeout counter in sub-module uart_rx_timeout.

Verification
REQ-039 Scenario: set IER=4'b0010 with tx_empty_i=1 -> next cycle iir_o=8'h02, irq_o=1; a THR write then gives iir_o=8'h01.
REQ-040 Scenario: set fifo_ena_i=1, threshold 4, ERBFI=1, then push 4 bytes -> iir_o=8'hC4; after one pop, iir_o=8'hC1.
REQ-041 Scenario: with 8N1 (wls=11, pen=0, stb=0), 1 byte in the FIFO and no activity -> cti_p sets after exactly 640 baud_ticks and iir_o=8'hCC; a pop clears it.
REQ-042 Scenario: lsr_err_i pulse while RDA and THRE are both pending -> iir id=011; after the LSR read, id=010.
REQ-043 Scenario: msr_delta_i and an MSR read in the same cycle -> msr_p=1; with EDSSI=1, iir_o[3:0]=4'b0000.
REQ-044 Scenario: assert rst while cti_p and rls_p are set -> next cycle iir_o=8'h01, irq_o=0, ier_o=0.
